daq_frame_builder: RTL and testbench
====================================

Name: daq_frame_builder

Overview:
Readout-side stage directly downstream of the 16-channel sample FIFO block, in the RDCLK domain. Pops one L1A descriptor per event, then drains (SAMP_MAX+1)*6 12-bit words from each of the 16 channel FIFOs in lock-step. Emits a framed 16-bit word stream: 4 header words, channel data words, 2 trailer words, with valid/ready backpressure. Feeds the DAQ link serializer.

Parameters:
TMO_CYC, 1023, cycles to wait on a channel FIFO empty before the event is aborted with a timeout error
HDR_TAG, 4'hA, top nibble of header words

Ports:
RDCLK  in  1  readout clock; all logic on posedge
RST  in  1  synchronous active-high reset
RDY  in  1  L1A descriptor FIFO not empty
L1A_RD_EN  out  1  single-cycle pop of descriptor FIFO
L1A_SMP_IN  in  38  {phase, match, l1amcnt[11:0], l1acnt[23:0]}; valid 1 cycle after L1A_RD_EN
OVRLP_SMP_IN  in  7  overlap info; valid 2 cycles after L1A_RD_EN
FIFO_EMPTY  in  16  channel FIFO empty flags
RD_ENA  out  16  channel FIFO read enables, always all-equal
DIN_16CH  in  192  ch n at [12n+11:12n]; valid 1 cycle after RD_ENA
SAMP_MAX  in  7  samples per event minus 1; latched at event start
DOUT  out  16  output word
DOUT_VALID  out  1  DOUT valid
DOUT_LAST  out  1  marks final trailer word
DOUT_READY  in  1  downstream accept
BUSY  out  1  high from descriptor pop until last word accepted
EVT_CNT  out  16  completed events, wraps at 0xFFFF
TMO_ERR  out  1  sticky; set on timeout, cleared only by RST

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; latched descriptor 0.
- Transfer occurs on DOUT_VALID & DOUT_READY. While VALID and not READY, DOUT/DOUT_LAST hold stable. VALID never drops without a transfer.
- States:
  - IDLE: if RDY, assert L1A_RD_EN for 1 cycle, latch SAMP_MAX, go L1A_W1.
  - L1A_W1: capture L1A_SMP_IN. Go L1A_W2.
  - L1A_W2: capture OVRLP_SMP_IN. Go HDR.
  - HDR: emit 4 words in order:
    - H0 = {HDR_TAG, l1acnt[23:12]}
    - H1 = {HDR_TAG, l1acnt[11:0]}
    - H2 = {HDR_TAG, l1amcnt}
    - H3 = {HDR_TAG, phase, match, 3'b000, ovrlp[6:0]}
  - CH_CHK: if FIFO_EMPTY==0, pulse RD_ENA=16'hFFFF for 1 cycle, go CH_W. Else increment wait counter. At TMO_CYC, set TMO_ERR and abort flag, go TRL. Counter clears on each successful read.
  - CH_W: capture DIN_16CH into 192-bit holding register. Go DATA.
  - DATA: emit 16 words, ch 0..15: {ch[3:0], adc[11:0]}. Then increment block counter. If block == (SAMP_MAX_latched+1)*6, go TRL; else go CH_CHK.
  - TRL: emit T0 = {4'hE, dwc[11:0]}, where dwc = data words emitted mod 4096. Then emit T1 = {4'hF, abort, partial-FIFO flag, 10'b0} with DOUT_LAST=1.
  - After the T1 transfer: EVT_CNT+1, go IDLE. BUSY drops the same cycle.
- Block-count width is 10 bits; the maximum is 768 blocks (12288 data words).
- Partial-FIFO flag: set if FIFO_EMPTY was non-uniform (some but not all set) in any CH_CHK cycle of the event.
- No channel read is issued unless all 16 are non-empty; there is never a partial read.
- Back-to-back events: IDLE samples RDY the cycle after the last transfer; minimum 1 idle cycle between events.
- RST mid-event: immediate return to IDLE with no further pops or reads. A partially sent frame is abandoned; downstream resynchronizes on HDR_TAG.

Test Plan:
- Single event, SAMP_MAX=0, DOUT_READY=1, ch n data = 12'h100+n, l1acnt=24'h123456:
  - output A123, A456, header words, then 96 data words, E060, F000 with LAST.
  - EVT_CNT=1; exactly 6 RD_ENA pulses and 1 L1A_RD_EN pulse.
- Backpressure: toggle DOUT_READY pseudo-randomly on the above event -> identical word sequence; DOUT stable whenever VALID&!READY.
- Starvation: FIFO_EMPTY[7] stuck high after 2 blocks -> after TMO_CYC cycles, T0=E020, T1=F000|0xC00 with LAST; TMO_ERR=1 until RST.
- SAMP_MAX=127 event -> 12288 data words; T0=E000 (12288 mod 4096); block counter reaches 768 without wrap.
- RST asserted during DATA word 5 -> next cycle all outputs 0, no RD_ENA/L1A_RD_EN. A following event frames correctly from H0.
- Two queued descriptors (RDY held high) -> two complete frames, EVT_CNT=2, second L1A_RD_EN only after first DOUT_LAST transfer.

Source files
------------

// File: rtl/daq_frame_builder_if.sv
// Framed output word stream towards the DAQ link serializer.
// A word moves on a cycle where DOUT_VALID and DOUT_READY are both high.
interface daq_frame_builder_if;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_LAST;
  logic        DOUT_READY;

  modport master (
    output DOUT,
    output DOUT_VALID,
    output DOUT_LAST,
    input  DOUT_READY
  );

  modport slave (
    input  DOUT,
    input  DOUT_VALID,
    input  DOUT_LAST,
    output DOUT_READY
  );
endinterface

// File: rtl/daq_frame_builder.sv
// DAQ frame builder.
// Pops one L1A descriptor per event, reads all 16 channel FIFOs in lock-step
// and emits a framed 16-bit word stream: 4 header words, the channel data
// words and 2 trailer words.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | wait for a descriptor; pop it and latch SAMP_MAX
// S_L1A_W1 | descriptor word is on L1A_SMP_IN; capture it
// S_L1A_W2 | overlap info is on OVRLP_SMP_IN; capture it
// S_HDR    | emit header words H0..H3
// S_CH_CHK | wait until all 16 FIFOs are non-empty, then read; time out
// S_CH_W   | channel data is on DIN_16CH; capture it
// S_DATA   | emit the 16 captured channel words
// S_TRL    | emit trailer words T0 (word count) and T1 (status, LAST)
module daq_frame_builder #(
  parameter int unsigned TMO_CYC = 1023,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic                RDCLK,
  input  logic                RST,
  input  logic                RDY,
  output logic                L1A_RD_EN,
  input  logic [37:0]         L1A_SMP_IN,
  input  logic [6:0]          OVRLP_SMP_IN,
  input  logic [15:0]         FIFO_EMPTY,
  output logic [15:0]         RD_ENA,
  input  logic [191:0]        DIN_16CH,
  input  logic [6:0]          SAMP_MAX,
  daq_frame_builder_if.master dout_if,
  output logic                BUSY,
  output logic [15:0]         EVT_CNT,
  output logic                TMO_ERR
);

  // The wait timer counts down from TMO_CYC-1; a timeout is declared on the
  // empty cycle that finds it already at zero, i.e. the TMO_CYC-th one.
  localparam int unsigned     WW      = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [WW-1:0]   WAIT_LD = WW'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1A_W1,
    S_L1A_W2,
    S_HDR,
    S_CH_CHK,
    S_CH_W,
    S_DATA,
    S_TRL
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [37:0]   r_l1a;
  logic [6:0]    r_ovrlp;
  logic [9:0]    r_blk_tgt;
  logic [9:0]    r_blk_cnt;
  logic [3:0]    r_idx;
  logic [11:0]   r_hold [16];
  logic [11:0]   r_dwc;
  logic [WW-1:0] r_wait;
  logic          r_abort;
  logic          r_partial;
  logic          r_tmo_err;
  logic [15:0]   r_evt_cnt;

  logic          w_l1a_rd_en;
  logic          w_rd;
  logic          w_valid;
  logic          w_last;
  logic [15:0]   w_dout;
  logic          w_xfer;
  logic          w_fifo_ok;
  logic          w_fifo_mixed;
  logic          w_blk_done;

  assign w_fifo_ok    = (FIFO_EMPTY == 16'h0000);
  assign w_fifo_mixed = (FIFO_EMPTY != 16'h0000) && (FIFO_EMPTY != 16'hFFFF);
  assign w_blk_done   = ((r_blk_cnt + 10'd1) == r_blk_tgt);
  assign w_xfer       = w_valid & dout_if.DOUT_READY;

  // Next-state decode and the combinational outputs of the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_l1a_rd_en = 1'b0;
    w_rd        = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_dout      = 16'h0000;
    case (r_state)
      S_IDLE: begin
        // Pops are held off during reset so no descriptor is lost.
        if (RDY && !RST) begin
          w_l1a_rd_en = 1'b1;
          w_state_nxt = S_L1A_W1;
        end
      end
      S_L1A_W1: w_state_nxt = S_L1A_W2;
      S_L1A_W2: w_state_nxt = S_HDR;
      S_HDR: begin
        w_valid = 1'b1;
        case (r_idx[1:0])
          2'd0:    w_dout = {HDR_TAG, r_l1a[23:12]};
          2'd1:    w_dout = {HDR_TAG, r_l1a[11:0]};
          2'd2:    w_dout = {HDR_TAG, r_l1a[35:24]};
          default: w_dout = {HDR_TAG, r_l1a[37], r_l1a[36], 3'b000, r_ovrlp};
        endcase
        if (dout_if.DOUT_READY && (r_idx[1:0] == 2'd3)) w_state_nxt = S_CH_CHK;
      end
      S_CH_CHK: begin
        if (w_fifo_ok) begin
          w_rd        = !RST;
          w_state_nxt = S_CH_W;
        end else if (r_wait == '0) begin
          w_state_nxt = S_TRL;
        end
      end
      S_CH_W: w_state_nxt = S_DATA;
      S_DATA: begin
        w_valid = 1'b1;
        w_dout  = {r_idx, r_hold[r_idx]};
        if (dout_if.DOUT_READY && (r_idx == 4'd15))
          w_state_nxt = w_blk_done ? S_TRL : S_CH_CHK;
      end
      S_TRL: begin
        w_valid = 1'b1;
        if (!r_idx[0]) begin
          w_dout = {4'hE, r_dwc};
        end else begin
          w_dout = {4'hF, r_abort, r_partial, 10'b0};
          w_last = 1'b1;
        end
        if (dout_if.DOUT_READY && r_idx[0]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge RDCLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Event datapath: descriptor capture, word index, block/word counters,
  // wait timer and status flags.
  always_ff @(posedge RDCLK) begin
    if (RST) begin
      r_l1a     <= '0;
      r_ovrlp   <= '0;
      r_blk_tgt <= '0;
      r_blk_cnt <= '0;
      r_idx     <= '0;
      r_dwc     <= '0;
      r_wait    <= '0;
      r_abort   <= 1'b0;
      r_partial <= 1'b0;
      r_tmo_err <= 1'b0;
      r_evt_cnt <= '0;
      for (int i = 0; i < 16; i++) r_hold[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_l1a_rd_en) begin
            r_blk_tgt <= ({3'b000, SAMP_MAX} + 10'd1) * 10'd6;
            r_blk_cnt <= '0;
            r_idx     <= '0;
            r_dwc     <= '0;
            r_wait    <= WAIT_LD;
            r_abort   <= 1'b0;
            r_partial <= 1'b0;
          end
        end
        S_L1A_W1: r_l1a   <= L1A_SMP_IN;
        S_L1A_W2: r_ovrlp <= OVRLP_SMP_IN;
        S_HDR: begin
          if (w_xfer) r_idx <= (r_idx[1:0] == 2'd3) ? 4'd0 : r_idx + 4'd1;
        end
        S_CH_CHK: begin
          if (w_fifo_mixed) r_partial <= 1'b1;
          if (w_fifo_ok) begin
            r_wait <= WAIT_LD;
          end else if (r_wait == '0) begin
            r_abort   <= 1'b1;
            r_tmo_err <= 1'b1;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_CH_W: begin
          for (int i = 0; i < 16; i++) r_hold[i] <= DIN_16CH[12*i +: 12];
        end
        S_DATA: begin
          if (w_xfer) begin
            r_idx <= r_idx + 4'd1;
            r_dwc <= r_dwc + 12'd1;
            if (r_idx == 4'd15) r_blk_cnt <= r_blk_cnt + 10'd1;
          end
        end
        S_TRL: begin
          if (w_xfer) begin
            if (r_idx[0]) begin
              r_idx     <= 4'd0;
              r_evt_cnt <= r_evt_cnt + 16'd1;
            end else begin
              r_idx <= 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign L1A_RD_EN          = w_l1a_rd_en;
  assign RD_ENA             = {16{w_rd}};
  assign dout_if.DOUT       = w_dout;
  assign dout_if.DOUT_VALID = w_valid;
  assign dout_if.DOUT_LAST  = w_last;
  assign BUSY               = (r_state != S_IDLE) || w_l1a_rd_en;
  assign EVT_CNT            = r_evt_cnt;
  assign TMO_ERR            = r_tmo_err;

endmodule

// File: tb/tb_daq_frame_builder.sv
// Bench for daq_frame_builder: descriptor/channel FIFO models feed the DUT,
// an expected-word queue built from the frame format is checked on every
// transfer, plus literal checks on selected frames.
module tb_daq_frame_builder;

  typedef struct {
    logic [37:0] l1a;
    logic [6:0]  ovr;
    logic [6:0]  smax;
  } desc_t;

  logic         RDCLK = 1'b0;
  logic         RST = 1'b1;
  logic         RDY = 1'b0;
  logic         L1A_RD_EN;
  logic [37:0]  L1A_SMP_IN = '0;
  logic [6:0]   OVRLP_SMP_IN = '0;
  logic [15:0]  FIFO_EMPTY = 16'hFFFF;
  logic [15:0]  RD_ENA;
  logic [191:0] DIN_16CH = '0;
  logic [6:0]   SAMP_MAX = '0;
  logic         BUSY;
  logic [15:0]  EVT_CNT;
  logic         TMO_ERR;

  daq_frame_builder_if dif();

  daq_frame_builder #(.TMO_CYC(1023), .HDR_TAG(4'hA)) dut (
    .RDCLK        (RDCLK),
    .RST          (RST),
    .RDY          (RDY),
    .L1A_RD_EN    (L1A_RD_EN),
    .L1A_SMP_IN   (L1A_SMP_IN),
    .OVRLP_SMP_IN (OVRLP_SMP_IN),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .RD_ENA       (RD_ENA),
    .DIN_16CH     (DIN_16CH),
    .SAMP_MAX     (SAMP_MAX),
    .dout_if      (dif),
    .BUSY         (BUSY),
    .EVT_CNT      (EVT_CNT),
    .TMO_ERR      (TMO_ERR)
  );

  initial forever #5 RDCLK = ~RDCLK;

  int cyc = 0;
  always @(posedge RDCLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  desc_t        desc_q[$];
  logic [191:0] blk_q[$];
  logic [16:0]  exp_q[$];
  logic [16:0]  frm_log[$];
  int           pop_cyc[$];
  int           last_cyc[$];
  int           n_pop = 0;
  int           n_rd = 0;
  int           exp_evt = 0;
  logic [15:0]  empty_pat = 16'hFFFF;
  bit           stall_en = 1'b0;
  bit           bp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference model: the whole frame follows from the descriptor, the number
  // of blocks the FIFOs will supply and the empty pattern once they run dry.
  task automatic queue_event(input logic [37:0] l1a, input logic [6:0] ovr,
                             input logic [6:0] smax, input int avail, input bit fixed);
    int need, sent;
    bit abort, partial;
    logic [191:0] blk;
    logic [11:0] v;
    logic [11:0] dwc;
    desc_t d;
    need    = (int'(smax) + 1) * 6;
    sent    = (avail < need) ? avail : need;
    abort   = (avail < need);
    partial = abort && (empty_pat != 16'h0000) && (empty_pat != 16'hFFFF);
    d.l1a = l1a; d.ovr = ovr; d.smax = smax;
    desc_q.push_back(d);
    exp_q.push_back({1'b0, 4'hA, l1a[23:12]});
    exp_q.push_back({1'b0, 4'hA, l1a[11:0]});
    exp_q.push_back({1'b0, 4'hA, l1a[35:24]});
    exp_q.push_back({1'b0, 4'hA, l1a[37], l1a[36], 3'b000, ovr});
    for (int b = 0; b < sent; b++) begin
      blk = '0;
      for (int ch = 0; ch < 16; ch++) begin
        v = fixed ? (12'h100 + 12'(ch)) : 12'($urandom());
        blk[ch*12 +: 12] = v;
        exp_q.push_back({1'b0, 4'(ch), v});
      end
      blk_q.push_back(blk);
    end
    dwc = 12'(sent * 16);
    exp_q.push_back({1'b0, 4'hE, dwc});
    exp_q.push_back({1'b1, 4'hF, abort, partial, 10'b0});
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge RDCLK);
      n++;
    end while ((exp_q.size() != 0 || BUSY || RDY) && n < maxc);
    vectors++;
    if (n >= maxc) begin
      miscompares++;
      $display("FAIL %s timeout: %0d words still expected, BUSY=%0b", nm, exp_q.size(), BUSY);
    end
    repeat (2) @(negedge RDCLK);
    #2;
  endtask

  task automatic do_reset();
    @(negedge RDCLK); #1;
    RST = 1'b1;
    exp_q.delete(); blk_q.delete(); desc_q.delete();
    exp_evt = 0;
    repeat (2) @(negedge RDCLK);
    #1 RST = 1'b0;
    @(negedge RDCLK); #2;
  endtask

  // Descriptor and channel FIFO models; also random backpressure.
  initial begin : drv
    bit          pop_s;
    logic [15:0] rde_s, emp_s;
    int          cyc_s;
    desc_t       d;
    logic [6:0]  ovr_hold;
    bit          ovr_next;
    ovr_next = 1'b0;
    ovr_hold = '0;
    dif.DOUT_READY = 1'b0;
    forever begin
      @(negedge RDCLK);
      pop_s = L1A_RD_EN; rde_s = RD_ENA; emp_s = FIFO_EMPTY; cyc_s = cyc;
      if (!RST) begin
        vectors++;
        if (rde_s != 16'h0000 && rde_s != 16'hFFFF) begin
          miscompares++;
          $display("FAIL rd_ena_uniform: got %h want 0000 or ffff", rde_s);
        end
        if (rde_s == 16'hFFFF) begin
          vectors++;
          if (emp_s != 16'h0000) begin
            miscompares++;
            $display("FAIL rd_while_empty: FIFO_EMPTY %h want 0000", emp_s);
          end
        end
      end
      if (pop_s) begin
        vectors++;
        if (desc_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_on_empty: L1A_RD_EN 1 want 0");
        end
      end
      @(posedge RDCLK); #1;
      L1A_SMP_IN   = 38'({$urandom(), $urandom()});
      OVRLP_SMP_IN = 7'($urandom());
      DIN_16CH     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (ovr_next) begin
        OVRLP_SMP_IN = ovr_hold;
        ovr_next = 1'b0;
      end
      if (pop_s) begin
        n_pop++;
        pop_cyc.push_back(cyc_s);
        if (desc_q.size() > 0) begin
          d = desc_q.pop_front();
          L1A_SMP_IN = d.l1a;
          ovr_hold = d.ovr;
          ovr_next = 1'b1;
        end
      end
      if (rde_s == 16'hFFFF) begin
        n_rd++;
        if (blk_q.size() > 0) DIN_16CH = blk_q.pop_front();
      end
      RDY = (desc_q.size() > 0);
      SAMP_MAX = RDY ? desc_q[0].smax : 7'($urandom());
      if (blk_q.size() == 0)                           FIFO_EMPTY = empty_pat;
      else if (stall_en && $urandom_range(0, 3) == 0) FIFO_EMPTY = 16'hFFFF;
      else                                             FIFO_EMPTY = 16'h0000;
      dif.DOUT_READY = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output checker: every transfer against the model, hold rules, EVT_CNT.
  initial begin : cmp
    bit          prev_hold;
    logic [16:0] prev_word, got, want;
    prev_hold = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge RDCLK);
      if (RST) begin
        prev_hold = 1'b0;
        continue;
      end
      vectors++;
      if (EVT_CNT !== 16'(exp_evt)) begin
        miscompares++;
        $display("FAIL evt_cnt: got %0d want %0d", EVT_CNT, exp_evt);
      end
      got = {dif.DOUT_LAST, dif.DOUT};
      if (dif.DOUT_VALID) begin
        vectors++;
        if (!BUSY) begin
          miscompares++;
          $display("FAIL busy_with_valid: BUSY 0 want 1");
        end
        if (prev_hold) begin
          vectors++;
          if (got !== prev_word) begin
            miscompares++;
            $display("FAIL hold_stable: got %h want %h", got, prev_word);
          end
        end
        if (dif.DOUT_READY) begin
          frm_log.push_back(got);
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %h want none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              miscompares++;
              $display("FAIL word: got %h want %h", got, want);
            end
          end
          if (got[16]) begin
            exp_evt++;
            last_cyc.push_back(cyc);
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_word = got;
        end
      end else begin
        if (prev_hold) begin
          vectors++;
          miscompares++;
          $display("FAIL valid_dropped: DOUT_VALID 0 want 1");
        end
        prev_hold = 1'b0;
      end
    end
  end

  localparam logic [37:0] L1A_A = {1'b1, 1'b0, 12'h789, 24'h123456};

  initial begin : main
    int nev, np0, nr0, n;
    logic [16:0] w5;
    repeat (3) @(negedge RDCLK);
    chk("rst_dout",  {15'd0, dif.DOUT_VALID, dif.DOUT}, 32'h0);
    chk("rst_last",  dif.DOUT_LAST, 0);
    chk("rst_busy",  BUSY, 0);
    chk("rst_evt",   EVT_CNT, 0);
    chk("rst_tmo",   TMO_ERR, 0);
    chk("rst_rd",    {L1A_RD_EN, RD_ENA}, 0);
    #1 RST = 1'b0;
    @(negedge RDCLK); #2;

    // Single fixed event, no backpressure.
    frm_log.delete(); n_pop = 0; n_rd = 0;
    queue_event(L1A_A, 7'h15, 7'd0, 100000, 1'b1);
    wait_done(2000, "evt_a");
    chk("a_len", frm_log.size(), 102);
    chk("a_h0", frm_log[0], 17'h0A123);
    chk("a_h1", frm_log[1], 17'h0A456);
    chk("a_h2", frm_log[2], 17'h0A789);
    chk("a_h3", frm_log[3], 17'h0A815);
    chk("a_d0", frm_log[4], 17'h00100);
    chk("a_d1", frm_log[5], 17'h01101);
    chk("a_d15", frm_log[19], 17'h0F10F);
    chk("a_t0", frm_log[100], 17'h0E060);
    chk("a_t1", frm_log[101], 17'h1F000);
    chk("a_evt", EVT_CNT, 1);
    chk("a_rd_pulses", n_rd, 6);
    chk("a_pops", n_pop, 1);

    // Same event under random backpressure.
    bp_en = 1'b1;
    frm_log.delete();
    queue_event(L1A_A, 7'h15, 7'd0, 100000, 1'b1);
    wait_done(4000, "evt_a_bp");
    chk("abp_len", frm_log.size(), 102);
    chk("abp_t0", frm_log[100], 17'h0E060);
    chk("abp_evt", EVT_CNT, 2);

    // Random events with FIFO stalls and backpressure, some queued in pairs.
    stall_en = 1'b1;
    nev = 2;
    for (int e = 0; e < 8; e++) begin
      queue_event(38'({$urandom(), $urandom()}), 7'($urandom()),
                  7'($urandom_range(0, 3)), 100000, 1'b0);
      nev++;
      if (e % 3 == 0) begin
        queue_event(38'({$urandom(), $urandom()}), 7'($urandom()),
                    7'($urandom_range(0, 3)), 100000, 1'b0);
        nev++;
      end
      wait_done(8000, "rand_evt");
    end
    chk("rand_evt_cnt", EVT_CNT, nev);
    chk("rand_tmo", TMO_ERR, 0);

    // Starvation: two blocks, then channel 7 stays empty.
    stall_en = 1'b0;
    bp_en = 1'b0;
    empty_pat = 16'h0080;
    frm_log.delete();
    queue_event(38'({$urandom(), $urandom()}), 7'($urandom()), 7'd0, 2, 1'b0);
    wait_done(5000, "starve");
    empty_pat = 16'hFFFF;
    chk("st_len", frm_log.size(), 38);
    chk("st_t0", frm_log[36], 17'h0E020);
    chk("st_t1", frm_log[37], 17'h1FC00);
    chk("st_tmo", TMO_ERR, 1);
    nev++;
    chk("st_evt", EVT_CNT, nev);

    // Full-size event: 768 blocks, word count wraps to 0 in T0.
    frm_log.delete();
    queue_event(38'({$urandom(), $urandom()}), 7'($urandom()), 7'd127, 100000, 1'b0);
    wait_done(40000, "big");
    chk("big_len", frm_log.size(), 12294);
    chk("big_t0", frm_log[12292], 17'h0E000);
    chk("big_t1", frm_log[12293], 17'h1F000);
    chk("big_tmo_sticky", TMO_ERR, 1);

    // Reset while data word 5 of the first block is on DOUT.
    queue_event(L1A_A, 7'h15, 7'd0, 100000, 1'b1);
    n = 0;
    do begin
      @(negedge RDCLK);
      n++;
      w5 = {dif.DOUT_LAST, dif.DOUT};
    end while (!(dif.DOUT_VALID && w5 == 17'h05105) && n < 300);
    chk("mid_reach_word5", w5, 17'h05105);
    #1;
    RST = 1'b1;
    exp_q.delete(); desc_q.delete();
    exp_evt = 0;
    np0 = n_pop; nr0 = n_rd;
    @(negedge RDCLK);
    chk("mid_dout", {dif.DOUT_VALID, dif.DOUT_LAST, dif.DOUT}, 0);
    chk("mid_busy", BUSY, 0);
    chk("mid_evt", EVT_CNT, 0);
    chk("mid_tmo", TMO_ERR, 0);
    chk("mid_strobes", {L1A_RD_EN, RD_ENA}, 0);
    #1 RST = 1'b0;
    repeat (4) @(negedge RDCLK);
    chk("mid_no_pop", n_pop, np0);
    chk("mid_no_rd", n_rd, nr0);
    #2;
    blk_q.delete();
    frm_log.delete();
    queue_event(L1A_A, 7'h15, 7'd0, 100000, 1'b1);
    wait_done(2000, "after_rst");
    chk("ar_h0", frm_log[0], 17'h0A123);
    chk("ar_t1", frm_log[101], 17'h1F000);
    chk("ar_evt", EVT_CNT, 1);

    // Two descriptors queued together.
    do_reset();
    pop_cyc.delete(); last_cyc.delete();
    np0 = n_pop;
    queue_event(38'({$urandom(), $urandom()}), 7'($urandom()), 7'd1, 100000, 1'b0);
    queue_event(38'({$urandom(), $urandom()}), 7'($urandom()), 7'd0, 100000, 1'b0);
    wait_done(6000, "two_evt");
    chk("two_evt", EVT_CNT, 2);
    chk("two_pops", n_pop - np0, 2);
    chk("two_last_seen", last_cyc.size(), 2);
    if (pop_cyc.size() == 2 && last_cyc.size() == 2)
      chk("two_pop_after_last", pop_cyc[1] > last_cyc[0], 1);
    else
      chk("two_pop_log", pop_cyc.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
